// File: rtl/easy_serial_in.sv
// Deframes LSB-first send/out bursts, publishes a message after CONFIRM identical good frames, tracks link timeout.
// Latency: msg/msg_valid registered on the frame-end edge (1 edge after last bit); no backpressure, EN=0 discards.
module easy_serial_in #(
  parameter int MSG_W   = 4,
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             state_send,
  input  logic             state_out,
  output logic [MSG_W-1:0] msg,
  output logic             msg_valid,
  output logic             frame_err,
  output logic             link_ok
);

  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] BITS   = CNT_W'(MSG_W);
  localparam logic [3:0]       CONF   = 4'(CONFIRM);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RECV, OVERRUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [MSG_W-1:0]   shreg_q, shreg_d;
  logic [MSG_W-1:0]   cand_q, cand_d;
  logic [3:0]         match_q, match_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               msg_valid_q, msg_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               link_ok_q, link_ok_d;
  logic               prev_q;
  logic               good;
  logic               new_cand;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cand_d      = cand_q;
    match_d     = match_q;
    to_cnt_d    = to_cnt_q;
    msg_d       = msg_q;
    link_ok_d   = link_ok_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    good        = 1'b0;
    new_cand    = (shreg_q != cand_q);

    if (!EN) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (state_send && !prev_q) begin
            state_d   = RECV;
            shreg_d   = {{(MSG_W-1){1'b0}}, state_out};
            bit_cnt_d = CNT_W'(1);
          end
        end
        RECV: begin
          if (state_send) begin
            if (bit_cnt_q < BITS) begin
              shreg_d   = shreg_q | ({{(MSG_W-1){1'b0}}, state_out} << bit_cnt_q);
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
              state_d = OVERRUN;
            end
          end else begin
            state_d = IDLE;
            if (bit_cnt_q == BITS) begin
              good = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              match_d     = '0;
            end
          end
        end
        OVERRUN: begin
          if (!state_send) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            match_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase

      // A good frame ending on the expiry edge wins over the timeout.
      if (good) begin
        to_cnt_d  = '0;
        link_ok_d = 1'b1;
        if (new_cand) begin
          cand_d  = shreg_q;
          match_d = 4'd1;
        end else if (match_q != CONF) begin
          match_d = match_q + 1'b1;
        end
        if (match_d == CONF && (new_cand || match_q != CONF)) begin
          msg_d       = shreg_q;
          msg_valid_d = 1'b1;
        end
      end else begin
        if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_d == TO_MAX) begin
          link_ok_d = 1'b0;
          match_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      cand_q      <= '0;
      match_q     <= '0;
      to_cnt_q    <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      link_ok_q   <= 1'b0;
      prev_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      to_cnt_q    <= to_cnt_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      frame_err_q <= frame_err_d;
      link_ok_q   <= link_ok_d;
      prev_q      <= state_send;
    end
  end

  assign msg       = msg_q;
  assign msg_valid = msg_valid_q;
  assign frame_err = frame_err_q;
  assign link_ok   = link_ok_q;

endmodule

// File: tb/tb_easy_serial_in.sv
// Bench for easy_serial_in: expected messages queued as frames are sent, popped on each msg_valid.
module tb_easy_serial_in;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b1;
  logic       state_send = 1'b0;
  logic       state_out = 1'b0;
  logic [3:0] msg;
  logic       msg_valid;
  logic       frame_err;
  logic       link_ok;

  int         n_chk = 0;
  int         n_pass = 0;
  int         fe_cnt = 0;
  int         fe_base;
  logic [3:0] sb[$];

  easy_serial_in #(.MSG_W(4), .CONFIRM(2), .TIMEOUT(64)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .state_send (state_send),
    .state_out  (state_out),
    .msg        (msg),
    .msg_valid  (msg_valid),
    .frame_err  (frame_err),
    .link_ok    (link_ok)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge CLK) begin
    #1;
    if (msg_valid) begin
      if (sb.size() == 0) check("vld_unexpected", {31'd0, msg_valid}, 32'd0);
      else check("msg_pub", {28'd0, msg}, {28'd0, sb.pop_front()});
    end
    if (frame_err) fe_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bits(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      state_send = 1'b1;
      state_out  = d[i%8];
    end
    @(negedge CLK);
    state_send = 1'b0;
    state_out  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] m);
    send_bits(4, {4'd0, m});
  endtask

  initial begin
    idle(2);
    #1;
    check("rst_msg", {28'd0, msg}, 32'd0);
    check("rst_vld", {31'd0, msg_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_link", {31'd0, link_ok}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(2);

    // two identical frames confirm 4'hA
    send_frame(4'hA);
    idle(1);
    check("link_first", {31'd0, link_ok}, 32'd1);
    check("msg_first", {28'd0, msg}, 32'd0);
    sb.push_back(4'hA);
    send_frame(4'hA);
    idle(2);
    check("msg_A", {28'd0, msg}, 32'hA);
    check("sb_empty_A", sb.size(), 32'd0);

    // 3,5 then 5: single publication after the third frame
    send_frame(4'h3);
    send_frame(4'h5);
    idle(1);
    check("msg_hold_35", {28'd0, msg}, 32'hA);
    sb.push_back(4'h5);
    send_frame(4'h5);
    idle(2);
    check("msg_5", {28'd0, msg}, 32'h5);
    check("sb_empty_5", sb.size(), 32'd0);

    // short and overrun frames, then back-to-back C,C
    fe_base = fe_cnt;
    send_bits(3, 8'hFF);
    idle(1);
    check("ferr_short", fe_cnt, fe_base + 1);
    send_bits(6, 8'hFF);
    idle(1);
    check("ferr_overrun", fe_cnt, fe_base + 2);
    check("msg_after_err", {28'd0, msg}, 32'h5);
    sb.push_back(4'hC);
    send_frame(4'hC);
    send_frame(4'hC);
    @(posedge CLK);
    #1;
    check("msg_C", {28'd0, msg}, 32'hC);
    check("sb_empty_C", sb.size(), 32'd0);

    // timeout: counted from the frame-end edge just sampled
    repeat (63) @(posedge CLK);
    #1;
    check("link_before_to", {31'd0, link_ok}, 32'd1);
    @(posedge CLK);
    #1;
    check("link_at_to", {31'd0, link_ok}, 32'd0);
    check("msg_hold_to", {28'd0, msg}, 32'hC);
    sb.push_back(4'hC);
    send_frame(4'hC);
    send_frame(4'hC);
    send_frame(4'hC);
    idle(2);
    check("link_back", {31'd0, link_ok}, 32'd1);
    check("msg_C2", {28'd0, msg}, 32'hC);
    check("sb_empty_C2", sb.size(), 32'd0);

    // EN dropped mid-frame
    fe_base = fe_cnt;
    @(negedge CLK);
    state_send = 1'b1;
    state_out  = 1'b1;
    @(negedge CLK);
    state_out  = 1'b0;
    @(negedge CLK);
    EN = 1'b0;
    idle(2);
    state_send = 1'b0;
    idle(100);
    check("link_frozen", {31'd0, link_ok}, 32'd1);
    check("ferr_en_off", fe_cnt, fe_base);
    EN = 1'b1;
    idle(2);
    sb.push_back(4'h6);
    send_frame(4'h6);
    send_frame(4'h6);
    idle(2);
    check("msg_6", {28'd0, msg}, 32'h6);
    check("sb_empty_6", sb.size(), 32'd0);

    // reset during bit 2, strobe held high through release
    fe_base = fe_cnt;
    @(negedge CLK);
    state_send = 1'b1;
    state_out  = 1'b1;
    @(negedge CLK);
    state_out  = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("mid_rst_msg", {28'd0, msg}, 32'd0);
    check("mid_rst_link", {31'd0, link_ok}, 32'd0);
    check("mid_rst_vld", {31'd0, msg_valid}, 32'd0);
    idle(2);
    RST_N = 1'b1;
    idle(3);
    state_send = 1'b0;
    idle(2);
    check("ferr_after_rst", fe_cnt, fe_base);
    check("msg_after_rst", {28'd0, msg}, 32'd0);
    check("link_after_rst", {31'd0, link_ok}, 32'd0);
    sb.push_back(4'h9);
    send_frame(4'h9);
    send_frame(4'h9);
    idle(2);
    check("msg_9", {28'd0, msg}, 32'h9);
    check("sb_empty_9", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
